// File: rtl/enigma_pkg.sv
// Shared constants and state encoding for the Enigma output-side framer.
package enigma_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } framer_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: baud counter, bit index and shift register; o_tx is registered.
module uart_tx_core
    import enigma_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_done,
    output logic       o_bit_end,
    output logic [3:0] o_bit_idx
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     LAST_BIT = 4'(UART_FRAME_BITS - 1);

    logic          busy;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          tx;

    assign o_bit_end = busy && (baud_cnt == CNT_LAST);
    assign o_done    = o_bit_end && (bit_idx == LAST_BIT);
    assign o_bit_idx = bit_idx;
    assign o_tx      = tx;

    // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit;
    // the stop bit is shifted in behind the data so it falls out naturally.
    always_ff @(posedge i_clock or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
            tx       <= 1'b1;
        end else if (i_start && !busy) begin
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= {1'b1, i_byte};
            tx       <= 1'b0;
        end else if (busy) begin
            if (baud_cnt == CNT_LAST) begin
                baud_cnt <= '0;
                if (bit_idx == LAST_BIT) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/enigma_tx_framer.sv
// Buffers cipher bytes, groups them into 5-letter blocks with spaces,
// appends CR LF on flush and sends the stream as 8N1 UART.
module enigma_tx_framer
    import enigma_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16,
    parameter int GROUP_LEN    = 5
) (
    input  logic       i_clock,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_flush,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam int            GW         = $clog2(GROUP_LEN + 1);
    localparam logic [AW:0]   DEPTH      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GROUP_LAST = GW'(GROUP_LEN);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [GW-1:0] grp_cnt;
    logic [GW-1:0] grp_next;
    logic          flush_flag;
    logic          cr_sent;
    logic          cr_next;
    logic          lf_load;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          load;
    logic          more_work;
    logic [7:0]    sel_byte;

    framer_state_t state;
    framer_state_t state_next;

    logic       tx_done;
    logic       tx_bit_end;
    logic [3:0] tx_bit_idx;

    assign fifo_empty = (count == '0);
    assign o_full     = (count == DEPTH);
    assign push       = i_valid && !o_full;
    assign load       = (state == ST_LOAD);
    assign more_work  = !fifo_empty || push || flush_flag || i_flush;
    assign o_busy     = !fifo_empty || flush_flag || (state != ST_IDLE);

    // Byte selection in LOAD: pending space, then buffered data, then CR/LF.
    always_comb begin
        sel_byte = '0;
        pop      = 1'b0;
        grp_next = grp_cnt;
        cr_next  = cr_sent;
        lf_load  = 1'b0;
        if (load) begin
            if (!fifo_empty && grp_cnt == GROUP_LAST) begin
                sel_byte = ASCII_SPACE;
                grp_next = '0;
            end else if (!fifo_empty) begin
                sel_byte = mem[rd_ptr];
                pop      = 1'b1;
                grp_next = grp_cnt + GW'(1);
            end else if (flush_flag) begin
                grp_next = '0;
                if (!cr_sent) begin
                    sel_byte = ASCII_CR;
                    cr_next  = 1'b1;
                end else begin
                    sel_byte = ASCII_LF;
                    cr_next  = 1'b0;
                    lf_load  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (more_work) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_START;
            ST_START: if (tx_bit_end && tx_bit_idx == 4'd0) state_next = ST_DATA;
            ST_DATA:  if (tx_bit_end && tx_bit_idx == 4'd8) state_next = ST_STOP;
            ST_STOP:  if (tx_done) state_next = more_work ? ST_LOAD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            grp_cnt    <= '0;
            cr_sent    <= 1'b0;
            flush_flag <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state   <= state_next;
            grp_cnt <= grp_next;
            cr_sent <= cr_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (lf_load)      flush_flag <= 1'b0;
            else if (i_flush) flush_flag <= 1'b1;
            if (i_valid && o_full) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_core (
        .i_clock  (i_clock),
        .reset    (reset),
        .i_start  (load),
        .i_byte   (sel_byte),
        .o_tx     (o_tx),
        .o_done   (tx_done),
        .o_bit_end(tx_bit_end),
        .o_bit_idx(tx_bit_idx)
    );

endmodule

// File: tb/tb_enigma_tx_framer.sv
// Scoreboard bench: stimulus queues expected line bytes, a UART monitor decodes o_tx and compares.
module tb_enigma_tx_framer;

    localparam int CPB = 4;

    logic       i_clock = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] i_data  = '0;
    logic       i_valid = 1'b0;
    logic       i_flush = 1'b0;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    enigma_tx_framer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (16),
        .GROUP_LEN   (5)
    ) dut (
        .i_clock   (i_clock),
        .reset     (reset),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_flush   (i_flush),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_full    (o_full),
        .o_overflow(o_overflow)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART monitor: detection lands half a cycle into the start bit,
    // so bit k is sampled CPB*k + CPB/2 - 1 negedges later.
    bit         mon_active = 0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = '0;
    logic [7:0] mon_exp;

    always @(negedge i_clock) begin
        if (reset) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (o_tx === 1'b0) begin
                mon_active = 1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            for (int k = 1; k <= 8; k++)
                if (mon_cnt == CPB * k + CPB / 2 - 1) mon_byte[k-1] = o_tx;
            if (mon_cnt == CPB * 9 + CPB / 2 - 1) begin
                mon_active = 0;
                check("stop_bit", {31'd0, o_tx}, 32'd1);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_byte !== mon_exp) begin
                        errors++;
                        $display("FAIL line_byte: got 0x%0h, expected 0x%0h", mon_byte, mon_exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic fl);
        i_data  = b;
        i_valid = 1'b1;
        i_flush = fl;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(s[i], 1'b0);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {31'd0, o_busy}, 32'd0);
        tick();
        tick();
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    logic [8:0] frame;
    bit         full_seen;

    initial begin
        // Reset state
        tick();
        check("rst_tx", {31'd0, o_tx}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_full", {31'd0, o_full}, 32'd0);
        check("rst_ovf", {31'd0, o_overflow}, 32'd0);
        reset = 1'b0;
        tick();

        // Single byte with exact frame timing
        exp_q.push_back(8'h41);
        push(8'h41, 1'b0);
        check("lat_load_tx", {31'd0, o_tx}, 32'd1);
        check("lat_load_busy", {31'd0, o_busy}, 32'd1);
        tick();
        check("lat_start_low", {31'd0, o_tx}, 32'd0);
        frame = {1'b1, 8'h41};
        for (int k = 1; k <= 9; k++) begin
            repeat (CPB) tick();
            check($sformatf("single_bit%0d", k), {31'd0, o_tx}, {31'd0, frame[k-1]});
        end
        repeat (3) tick();
        check("single_busy_stop", {31'd0, o_busy}, 32'd1);
        tick();
        check("single_busy_drop", {31'd0, o_busy}, 32'd0);
        wait_idle("single");

        // Grouping
        do_reset();
        expect_str("HELLO WORLD AB");
        push_str("HELLOWORLDAB");
        wait_idle("group");
        check("group_ovf", {31'd0, o_overflow}, 32'd0);

        // Flush with the last byte, then a fresh letter
        do_reset();
        expect_str("AB");
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        push("A", 1'b0);
        push("B", 1'b1);
        wait_idle("flush");
        exp_q.push_back("C");
        push("C", 1'b0);
        wait_idle("after_flush");

        // Overflow: 20 pushes, 17 accepted
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i > 0 && i % 5 == 0) exp_q.push_back(8'h20);
            exp_q.push_back(8'(65 + i));
        end
        full_seen = 0;
        for (int i = 0; i < 20; i++) begin
            push(8'(65 + i), 1'b0);
            if (o_full) full_seen = 1;
        end
        check("ovf_full_seen", {31'd0, full_seen}, 32'd1);
        check("ovf_set", {31'd0, o_overflow}, 32'd1);
        wait_idle("ovf");
        check("ovf_sticky", {31'd0, o_overflow}, 32'd1);
        do_reset();
        check("ovf_cleared", {31'd0, o_overflow}, 32'd0);

        // Reset during data bit 3 of 'P'
        push_str("PQR");
        repeat (15) tick();
        check("mid_bit3", {31'd0, o_tx}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_tx", {31'd0, o_tx}, 32'd1);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_full", {31'd0, o_full}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_post_tx", {31'd0, o_tx}, 32'd1);
        expect_str("ABCDE F");
        push_str("ABCDEF");
        wait_idle("mid");

        // Double flush with empty FIFO
        do_reset();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        wait_idle("dflush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
